// File: rtl/rank_writeback_if.sv
// AXI write-channel bundle (aw/w/b) between rank_writeback and memory.
// master = write issuer, slave = memory side.
interface rank_writeback_if #(
  parameter int DATA_W = 512
);
  logic [15:0]         awid_m;
  logic [63:0]         awaddr_m;
  logic [7:0]          awlen_m;
  logic [2:0]          awsize_m;
  logic                awvalid_m;
  logic                awready_m;
  logic [15:0]         wid_m;
  logic [DATA_W-1:0]   wdata_m;
  logic [DATA_W/8-1:0] wstrb_m;
  logic                wlast_m;
  logic                wvalid_m;
  logic                wready_m;
  logic [15:0]         bid_m;
  logic [1:0]          bresp_m;
  logic                bvalid_m;
  logic                bready_m;

  modport master (
    output awid_m, awaddr_m, awlen_m,
    output awsize_m, awvalid_m,
    input  awready_m,
    output wid_m, wdata_m, wstrb_m,
    output wlast_m, wvalid_m,
    input  wready_m,
    input  bid_m, bresp_m, bvalid_m,
    output bready_m
  );

  modport slave (
    input  awid_m, awaddr_m, awlen_m,
    input  awsize_m, awvalid_m,
    output awready_m,
    input  wid_m, wdata_m, wstrb_m,
    input  wlast_m, wvalid_m,
    output wready_m,
    output bid_m, bresp_m, bvalid_m,
    input  bready_m
  );
endinterface

// File: rtl/rank_writeback.sv
// Packs 64-bit rank words into 512-bit lines and writes each line
// as a single-beat AXI burst, tracking outstanding B responses.
module rank_writeback #(
  parameter int AXI_ID          = 2,
  parameter int DATA_W          = 512,
  parameter int WORD_W          = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       base_addr,
  input  logic [63:0]       n_words,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  rank_writeback_if.master  axi,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LANES = DATA_W / WORD_W;
  localparam int SW    = $clog2(LANES);
  localparam int LW    = SW + 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW    = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ISSUE,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [63:0]       addr;
  logic [63:0]       remaining;
  logic [LW-1:0]     lane;
  logic [DATA_W-1:0] line;
  logic [DATA_W/8-1:0] strb;
  logic              aw_done;
  logic              w_done;
  logic [OW-1:0]     outstanding;

  logic          aw_valid;
  logic          w_valid;
  logic          in_hs;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hit;
  logic          line_end;
  logic          take;
  logic          drained;
  logic [SW-1:0] slot;

  assign slot  = lane[SW-1:0];
  assign in_hs = in_valid & in_ready;
  assign aw_hs = aw_valid & axi.awready_m;
  assign w_hs  = w_valid & axi.wready_m;
  assign take  = (state == IDLE) & start;

  // Late responses after a reset find outstanding == 0 and are dropped.
  assign b_hit = axi.bvalid_m
               & (axi.bid_m == 16'(AXI_ID))
               & (outstanding != '0);

  assign line_end = (aw_done | aw_hs) & (w_done | w_hs);
  assign drained  = (outstanding == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (n_words == '0) ? DRAIN : FILL;
      end
      FILL: begin
        if (lane == LW'(LANES) || remaining == '0)
          state_nx = ISSUE;
        else
          in_ready = 1'b1;
      end
      ISSUE: begin
        aw_valid = ~aw_done
                 & (outstanding != OW'(MAX_OUTSTANDING));
        w_valid  = ~w_done;
        if (line_end)
          state_nx = (remaining != '0) ? FILL : DRAIN;
      end
      DRAIN: begin
        if (drained) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      lane      <= '0;
      line      <= '0;
      strb      <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      if (take) begin
        addr      <= base_addr;
        remaining <= n_words;
      end
      if (in_hs) begin
        line[slot*WORD_W +: WORD_W] <= in_data;
        strb[slot*BW +: BW]         <= '1;
        lane      <= lane + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (state == ISSUE) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
        if (line_end) begin
          addr    <= addr + 64'd64;
          lane    <= '0;
          line    <= '0;
          strb    <= '0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      unique case ({aw_hs, b_hit})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= (state == DRAIN) & drained;
      if (take)
        busy <= 1'b1;
      else if (state == DRAIN && drained)
        busy <= 1'b0;
      if (take)
        err <= 1'b0;
      else if (b_hit && axi.bresp_m != 2'b00)
        err <= 1'b1;
    end
  end

  assign axi.awid_m    = 16'(AXI_ID);
  assign axi.awaddr_m  = addr;
  assign axi.awlen_m   = 8'd0;
  assign axi.awsize_m  = 3'b110;
  assign axi.awvalid_m = aw_valid;
  assign axi.wid_m     = 16'(AXI_ID);
  assign axi.wdata_m   = line;
  assign axi.wstrb_m   = strb;
  assign axi.wlast_m   = w_valid;
  assign axi.wvalid_m  = w_valid;
  assign axi.bready_m  = 1'b1;

endmodule

// File: tb/tb_rank_writeback.sv
// Directed + randomized bench for rank_writeback with a
// line-level reference model and a reactive AXI write slave.
module tb_rank_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base_addr = '0;
  logic [63:0] n_words = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        err;

  rank_writeback_if bus ();

  rank_writeback dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .n_words  (n_words),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .axi      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit aw_en = 1'b1;
  bit w_en = 1'b1;
  bit rnd_rdy = 1'b0;
  int b_lim = 1 << 30;
  int err_line = -1;

  int aw_cnt = 0;
  int w_cnt = 0;
  int b_cnt = 0;
  int done_cnt = 0;
  int done_pend = 0;
  bit done_err = 1'b0;
  int stab_err = 0;
  int field_err = 0;

  logic [63:0]  aw_log[$];
  logic [511:0] wd_log[$];
  logic [63:0]  ws_log[$];
  logic [63:0]  word_q[$];
  logic [63:0]  cur_w[$];
  logic [63:0]  cur_base;

  bit           hs = 1'b0;
  bit           aw_hold = 1'b0;
  bit           w_hold = 1'b0;
  logic [63:0]  aw_sv;
  logic [575:0] w_sv;

  // Stream source, memory slave and monitors, all at negedge.
  always @(negedge clk) begin
    if (hs && word_q.size() > 0) void'(word_q.pop_front());
    in_valid = (word_q.size() > 0) && ($urandom_range(3) != 0);
    in_data = (word_q.size() > 0) ? word_q[0] : '0;
    hs = in_valid && in_ready;

    if (done === 1'b1) begin
      done_cnt++;
      done_pend = aw_cnt - b_cnt;
      done_err = err;
    end
    if (bus.bready_m !== 1'b1) field_err++;

    if (aw_en && aw_cnt > b_cnt && b_cnt < b_lim
        && $urandom_range(1) == 0) begin
      bus.bvalid_m = 1'b1;
      bus.bid_m = 16'd2;
      bus.bresp_m = (b_cnt == err_line) ? 2'b10 : 2'b00;
      b_cnt++;
    end else if ($urandom_range(7) == 0) begin
      bus.bvalid_m = 1'b1;
      bus.bid_m = 16'd1;
      bus.bresp_m = 2'b11;
    end else begin
      bus.bvalid_m = 1'b0;
      bus.bid_m = 16'd0;
      bus.bresp_m = 2'b00;
    end

    bus.awready_m = aw_en && (!rnd_rdy || $urandom_range(1) == 1);
    bus.wready_m = w_en && (!rnd_rdy || $urandom_range(1) == 1);

    if (aw_hold && bus.awvalid_m && bus.awaddr_m !== aw_sv)
      stab_err++;
    if (w_hold && bus.wvalid_m
        && {bus.wdata_m, bus.wstrb_m} !== w_sv)
      stab_err++;
    aw_hold = bus.awvalid_m && !bus.awready_m;
    aw_sv = bus.awaddr_m;
    w_hold = bus.wvalid_m && !bus.wready_m;
    w_sv = {bus.wdata_m, bus.wstrb_m};

    if (bus.awvalid_m && bus.awready_m) begin
      aw_log.push_back(bus.awaddr_m);
      aw_cnt++;
      if (bus.awid_m !== 16'd2 || bus.awlen_m !== 8'd0
          || bus.awsize_m !== 3'b110)
        field_err++;
    end
    if (bus.wvalid_m && bus.wready_m) begin
      wd_log.push_back(bus.wdata_m);
      ws_log.push_back(bus.wstrb_m);
      w_cnt++;
      if (bus.wid_m !== 16'd2 || bus.wlast_m !== 1'b1)
        field_err++;
    end
  end

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic job_begin(input logic [63:0] base,
                           input int n, input bit seq);
    cur_w.delete();
    for (int i = 0; i < n; i++)
      cur_w.push_back(seq ? 64'(i + 1) : {$urandom, $urandom});
    cur_base = base;
    aw_log.delete();
    wd_log.delete();
    ws_log.delete();
    foreach (cur_w[i]) word_q.push_back(cur_w[i]);
  endtask

  task automatic pulse(input logic [63:0] base, input int n);
    @(negedge clk);
    base_addr = base;
    n_words = 64'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt != d0, 1'b1);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  // Reference: line i covers words 8i..8i+7 at base + 64*i.
  task automatic check_lines(input string tag, input bit exp_err);
    int n = cur_w.size();
    int nl = (n + 7) / 8;
    logic [511:0] ed;
    logic [63:0]  es;
    chk({tag, "_aw_n"}, aw_log.size(), nl);
    chk({tag, "_w_n"}, wd_log.size(), nl);
    chk({tag, "_pend"}, done_pend, 0);
    chk({tag, "_err"}, done_err, exp_err);
    for (int i = 0; i < nl; i++) begin
      if (i < aw_log.size() && i < wd_log.size()) begin
        ed = '0;
        es = '0;
        for (int k = 0; k < 8; k++) begin
          if (8 * i + k < n) begin
            ed[64*k +: 64] = cur_w[8*i+k];
            es[8*k +: 8] = 8'hFF;
          end
        end
        chk($sformatf("%s_addr%0d", tag, i),
            aw_log[i], cur_base + 64'(64 * i));
        chk($sformatf("%s_data%0d", tag, i), wd_log[i], ed);
        chk($sformatf("%s_strb%0d", tag, i), ws_log[i], es);
      end
    end
  endtask

  task automatic job(input string tag, input logic [63:0] base,
                     input int n, input bit seq);
    job_begin(base, n, seq);
    pulse(base, n);
    wait_done(tag);
    check_lines(tag, 1'b0);
  endtask

  initial begin
    int a0;
    int w0;
    int k;
    logic [63:0] rb;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_awvalid", bus.awvalid_m, 1'b0);
    chk("rst_wvalid", bus.wvalid_m, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_bready", bus.bready_m, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    job("t1", 64'h1000, 8, 1'b1);
    chk("t1_data_lane0", wd_log.size() > 0 ? wd_log[0][63:0] : '0,
        64'd1);

    job("t2", 64'h2000, 11, 1'b0);
    chk("t2_strb1", ws_log.size() > 1 ? ws_log[1] : '0,
        64'h0000_0000_00FF_FFFF);

    w_en = 1'b0;
    a0 = aw_cnt;
    w0 = w_cnt;
    job_begin(64'h3000, 8, 1'b0);
    pulse(64'h3000, 8);
    k = 0;
    while (aw_cnt == a0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk("t3_aw_once", aw_cnt - a0, 1);
    chk("t3_no_w", w_cnt - w0, 0);
    chk("t3_wvalid", bus.wvalid_m, 1'b1);
    chk("t3_awvalid", bus.awvalid_m, 1'b0);
    w_en = 1'b1;
    wait_done("t3");
    check_lines("t3", 1'b0);
    chk("t3_stable", stab_err, 0);

    b_lim = b_cnt;
    a0 = aw_cnt;
    job_begin(64'h4000, 80, 1'b0);
    pulse(64'h4000, 80);
    repeat (400) @(negedge clk);
    chk("t4_aw_cap", aw_cnt - a0, 8);
    chk("t4_aw_gated", bus.awvalid_m, 1'b0);
    chk("t4_busy", busy, 1'b1);
    b_lim = b_cnt + 1;
    repeat (30) @(negedge clk);
    chk("t4_aw_release", aw_cnt - a0, 9);
    b_lim = 1 << 30;
    wait_done("t4");
    check_lines("t4", 1'b0);

    a0 = aw_cnt;
    @(negedge clk);
    n_words = '0;
    base_addr = 64'h5000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy", busy, 1'b1);
    chk("t5_done_early", done, 1'b0);
    @(negedge clk);
    chk("t5_done", done, 1'b1);
    @(negedge clk);
    chk("t5_done_pulse", done, 1'b0);
    chk("t5_no_aw", aw_cnt - a0, 0);

    rnd_rdy = 1'b1;
    err_line = b_cnt + 1;
    job_begin(64'h6000, 16, 1'b0);
    pulse(64'h6000, 16);
    wait_done("t6e");
    check_lines("t6e", 1'b1);
    chk("t6e_sticky", err, 1'b1);
    err_line = -1;
    job_begin(64'h7000, 5, 1'b0);
    pulse(64'h7000, 5);
    chk("t6e_cleared", err, 1'b0);
    wait_done("t6c");
    check_lines("t6c", 1'b0);

    job_begin(64'h8000, 20, 1'b0);
    pulse(64'h8000, 20);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6r_in_ready", in_ready, 1'b0);
    chk("t6r_busy", busy, 1'b0);
    chk("t6r_awvalid", bus.awvalid_m, 1'b0);
    chk("t6r_wvalid", bus.wvalid_m, 1'b0);
    chk("t6r_done", done, 1'b0);
    @(negedge clk);
    word_q.delete();
    rst = 1'b0;
    @(negedge clk);
    job("t6r_new", 64'h9000, 13, 1'b0);

    for (int r = 0; r < 4; r++) begin
      rb = {32'h0, $urandom} & ~64'h3F;
      job($sformatf("rnd%0d", r), rb, $urandom_range(30, 1), 1'b0);
    end

    chk("fields", field_err, 0);
    chk("stable_all", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
